axi4l_regbank: RTL and testbench

- Register bank that sits directly downstream of the AXI4-Lite IP-interface bridge.
- Consumes the bridge's simple write/read request interfaces and returns a single-cycle ack with read data.
- Provides ID, scratch, control, status, a W1C interrupt block with enable mask and irq output, and a 64-bit free-running cycle counter with a coherent snapshot read.

---
 rtl/axi4l_regbank.sv | 176 +++++++++++++++++
 tb/tb_axi4l_regbank.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_regbank.sv
// Register bank behind the AXI4-Lite bridge: ID, scratch, control, status,
// W1C interrupt block with enable mask and irq, 64-bit cycle counter with
// a coherent CNT_LO/CNT_HI snapshot.
module axi4l_regbank #(
   parameter int unsigned C_ADDR_WIDTH = 12,
   parameter int unsigned C_DATA_WIDTH = 32,
   parameter logic [31:0] C_ID         = 32'h5247_0001,
   parameter int unsigned C_NUM_IRQ    = 8
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [C_ADDR_WIDTH-3:0] wr_addr,
   input  logic                    wr_req,
   input  logic [3:0]              wr_be,
   input  logic [31:0]             wr_data,
   output logic                    wr_ack,
   input  logic [C_ADDR_WIDTH-3:0] rd_addr,
   input  logic                    rd_req,
   output logic [31:0]             rd_data,
   output logic                    rd_ack,
   output logic [31:0]             ctrl_o,
   input  logic [31:0]             status_i,
   input  logic [C_NUM_IRQ-1:0]    irq_src_i,
   output logic                    irq
);

   localparam int unsigned AW = C_ADDR_WIDTH - 2;
   localparam int unsigned DW = 32;
   localparam int unsigned NI = C_NUM_IRQ;
   localparam int unsigned CW = 64;

   localparam logic [AW-1:0] IDX_ID       = AW'(0);
   localparam logic [AW-1:0] IDX_SCRATCH  = AW'(1);
   localparam logic [AW-1:0] IDX_CTRL     = AW'(2);
   localparam logic [AW-1:0] IDX_STATUS   = AW'(3);
   localparam logic [AW-1:0] IDX_INT_STAT = AW'(4);
   localparam logic [AW-1:0] IDX_INT_EN   = AW'(5);
   localparam logic [AW-1:0] IDX_CNT_LO   = AW'(6);
   localparam logic [AW-1:0] IDX_CNT_HI   = AW'(7);

   // CTRL bit1 is a strobe that clears the counter; it is never stored.
   localparam logic [DW-1:0] CTRL_CLR_BIT = DW'(2);

   // Reject illegal parameterisations at elaboration.
   if (C_DATA_WIDTH != 32) begin : g_dw_check
      $error("axi4l_regbank: C_DATA_WIDTH must be 32");
   end
   if ((C_NUM_IRQ < 1) || (C_NUM_IRQ > 32)) begin : g_irq_check
      $error("axi4l_regbank: C_NUM_IRQ must be in 1..32");
   end

   logic            wr_acc_c;
   logic            rd_acc_c;
   logic [DW-1:0]   be_mask_c;

   logic [DW-1:0]   scratch_q;
   logic [DW-1:0]   scratch_d;
   logic [DW-1:0]   ctrl_d;
   logic            cnt_clr_c;

   logic [NI-1:0]   int_stat_q;
   logic [NI-1:0]   int_stat_d;
   logic [NI-1:0]   int_en_q;
   logic [NI-1:0]   int_en_d;
   logic [NI-1:0]   src_q;
   logic [NI-1:0]   src_rise_c;
   logic [NI-1:0]   w1c_c;
   logic            irq_d;

   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [DW-1:0]   cnt_hi_q;
   logic [DW-1:0]   cnt_hi_d;

   logic [DW-1:0]   rd_mux_c;
   logic [DW-1:0]   rd_data_d;

   // Accept qualifiers: a held request is ignored during its own ack cycle.
   assign wr_acc_c  = wr_req & ~wr_ack;
   assign rd_acc_c  = rd_req & ~rd_ack;
   assign be_mask_c = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};

   // Write decode: byte-enable merges for RW registers, W1C mask, counter clear strobe.
   always_comb begin
      scratch_d = scratch_q;
      ctrl_d    = ctrl_o;
      int_en_d  = int_en_q;
      w1c_c     = '0;
      cnt_clr_c = 1'b0;
      if (wr_acc_c) begin
         case (wr_addr)
            IDX_SCRATCH: begin
               scratch_d = (scratch_q & ~be_mask_c) | (wr_data & be_mask_c);
            end
            IDX_CTRL: begin
               ctrl_d    = ((ctrl_o & ~be_mask_c) | (wr_data & be_mask_c)) & ~CTRL_CLR_BIT;
               cnt_clr_c = wr_data[1] & wr_be[0];
            end
            IDX_INT_STAT: begin
               w1c_c = wr_data[NI-1:0] & be_mask_c[NI-1:0];
            end
            IDX_INT_EN: begin
               int_en_d = (int_en_q & ~be_mask_c[NI-1:0]) |
                          (wr_data[NI-1:0] & be_mask_c[NI-1:0]);
            end
            default: begin
            end
         endcase
      end
   end

   // Interrupt status: rising edges set, W1C clears, a same-cycle set wins.
   always_comb begin
      src_rise_c = irq_src_i & ~src_q;
      int_stat_d = (int_stat_q & ~w1c_c) | src_rise_c;
      irq_d      = |(int_stat_q & int_en_q);
   end

   // Free-running counter: clear strobe has priority over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr_c) begin
         cnt_d = '0;
      end else if (ctrl_o[0]) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Read mux; a CNT_LO read latches the upper counter word into the shadow.
   always_comb begin
      rd_mux_c = '0;
      case (rd_addr)
         IDX_ID:       rd_mux_c = C_ID;
         IDX_SCRATCH:  rd_mux_c = scratch_q;
         IDX_CTRL:     rd_mux_c = ctrl_o;
         IDX_STATUS:   rd_mux_c = status_i;
         IDX_INT_STAT: rd_mux_c = DW'(int_stat_q);
         IDX_INT_EN:   rd_mux_c = DW'(int_en_q);
         IDX_CNT_LO:   rd_mux_c = cnt_q[DW-1:0];
         IDX_CNT_HI:   rd_mux_c = cnt_hi_q;
         default:      rd_mux_c = '0;
      endcase
      rd_data_d = rd_acc_c ? rd_mux_c : rd_data;
      cnt_hi_d  = (rd_acc_c && (rd_addr == IDX_CNT_LO)) ? cnt_q[CW-1:DW] : cnt_hi_q;
   end

   // State and registered outputs.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ack     <= 1'b0;
         rd_ack     <= 1'b0;
         rd_data    <= '0;
         ctrl_o     <= '0;
         irq        <= 1'b0;
         scratch_q  <= '0;
         int_stat_q <= '0;
         int_en_q   <= '0;
         src_q      <= '0;
         cnt_q      <= '0;
         cnt_hi_q   <= '0;
      end else begin
         wr_ack     <= wr_acc_c;
         rd_ack     <= rd_acc_c;
         rd_data    <= rd_data_d;
         ctrl_o     <= ctrl_d;
         irq        <= irq_d;
         scratch_q  <= scratch_d;
         int_stat_q <= int_stat_d;
         int_en_q   <= int_en_d;
         src_q      <= irq_src_i;
         cnt_q      <= cnt_d;
         cnt_hi_q   <= cnt_hi_d;
      end
   end

endmodule

// File: tb/tb_axi4l_regbank.sv
// Self-checking bench for axi4l_regbank: directed scenarios plus a randomized
// run against a register-level reference model.
module tb_axi4l_regbank;

   localparam int unsigned AW     = 10;
   localparam logic [31:0] ID_VAL = 32'h5247_0001;

   logic          aclk = 1'b0;
   logic          areset;
   logic [AW-1:0] wr_addr;
   logic          wr_req;
   logic [3:0]    wr_be;
   logic [31:0]   wr_data;
   logic          wr_ack;
   logic [AW-1:0] rd_addr;
   logic          rd_req;
   logic [31:0]   rd_data;
   logic          rd_ack;
   logic [31:0]   ctrl_o;
   logic [31:0]   status_i;
   logic [7:0]    irq_src_i;
   logic          irq;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [31:0] exp_scratch;

   axi4l_regbank #(
      .C_ADDR_WIDTH (12),
      .C_DATA_WIDTH (32),
      .C_ID         (ID_VAL),
      .C_NUM_IRQ    (8)
   ) dut (
      .aclk      (aclk),
      .areset    (areset),
      .wr_addr   (wr_addr),
      .wr_req    (wr_req),
      .wr_be     (wr_be),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .rd_addr   (rd_addr),
      .rd_req    (rd_req),
      .rd_data   (rd_data),
      .rd_ack    (rd_ack),
      .ctrl_o    (ctrl_o),
      .status_i  (status_i),
      .irq_src_i (irq_src_i),
      .irq       (irq)
   );

   always #5 aclk = ~aclk;

   // Edge index: after posedge k, cyc reads k at the following negedge.
   always @(posedge aclk) cyc <= cyc + 1;

   // Byte-enable merge as described for RW registers.
   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Bus write: returns latency in cycles and the index of the accept edge.
   task automatic bus_write(input logic [AW-1:0] a, input logic [3:0] be,
                            input logic [31:0] d, output int lat, output int acc);
      @(negedge aclk);
      wr_addr = a; wr_be = be; wr_data = d; wr_req = 1'b1; lat = 0;
      do begin @(negedge aclk); lat++; end while (wr_ack !== 1'b1 && lat < 16);
      acc = cyc;
      wr_req = 1'b0;
   endtask

   // Bus read: returns data, latency and the index of the accept edge.
   task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d,
                           output int lat, output int acc);
      @(negedge aclk);
      rd_addr = a; rd_req = 1'b1; lat = 0;
      do begin @(negedge aclk); lat++; end while (rd_ack !== 1'b1 && lat < 16);
      d = rd_data; acc = cyc;
      rd_req = 1'b0;
   endtask

   task automatic test_reset();
      logic [AW-1:0] idx [4];
      logic [31:0]   exp [4];
      logic [31:0]   d;
      int lat, acc;
      idx = '{AW'(0), AW'(1), AW'(4), AW'(7)};
      exp = '{ID_VAL, 32'h0, 32'h0, 32'h0};
      areset = 1'b1;
      repeat (3) @(negedge aclk);
      n_tests++;
      if ({wr_ack, rd_ack, irq, rd_data, ctrl_o} !== 67'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0", {wr_ack, rd_ack, irq, rd_data, ctrl_o});
      end
      areset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_read(idx[i], d, lat, acc);
         n_tests++;
         if (d !== exp[i]) begin
            n_fail++; $display("FAIL reset_read[%0d]: got %h required %h", idx[i], d, exp[i]);
         end
         n_tests++;
         if (lat !== 1) begin
            n_fail++; $display("FAIL rd_ack_latency: got %0d required 1", lat);
         end
         @(negedge aclk);
         n_tests++;
         if (rd_ack !== 1'b0) begin
            n_fail++; $display("FAIL rd_ack_width: got %b required 0", rd_ack);
         end
      end
   endtask

   task automatic test_scratch();
      logic [31:0] d;
      int lat, acc, acks;
      bus_write(AW'(1), 4'hF, 32'hA5A5_A5A5, lat, acc);
      bus_write(AW'(1), 4'b0101, 32'h1234_5678, lat, acc);
      bus_read(AW'(1), d, lat, acc);
      n_tests++;
      if (d !== 32'hA534_A578) begin
         n_fail++; $display("FAIL scratch_be: got %h required a534a578", d);
      end
      exp_scratch = $urandom;
      @(negedge aclk);
      wr_addr = AW'(1); wr_be = 4'hF; wr_data = exp_scratch; wr_req = 1'b1; acks = 0;
      repeat (2) begin @(negedge aclk); if (wr_ack === 1'b1) acks++; end
      wr_req = 1'b0;
      repeat (3) begin @(negedge aclk); if (wr_ack === 1'b1) acks++; end
      n_tests++;
      if (acks !== 1) begin
         n_fail++; $display("FAIL held_wr_req_acks: got %0d required 1", acks);
      end
      bus_read(AW'(1), d, lat, acc);
      n_tests++;
      if (d !== exp_scratch) begin
         n_fail++; $display("FAIL scratch_full: got %h required %h", d, exp_scratch);
      end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      int lat, acc;
      bus_write(AW'(5), 4'h1, 32'h1, lat, acc);
      @(negedge aclk); irq_src_i = 8'h01;
      @(negedge aclk);
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b required 0", irq); end
      irq_src_i = 8'h00;
      @(negedge aclk);
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_assert: got %b required 1", irq); end
      bus_read(AW'(4), d, lat, acc);
      n_tests++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL int_stat_set: got %h required 1", d); end
      @(negedge aclk);
      wr_addr = AW'(4); wr_be = 4'hF; wr_data = 32'h1; wr_req = 1'b1; irq_src_i = 8'h01;
      @(negedge aclk);
      n_tests++;
      if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL w1c_ack: got %b required 1", wr_ack); end
      wr_req = 1'b0; irq_src_i = 8'h00;
      bus_read(AW'(4), d, lat, acc);
      n_tests++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL set_wins: got %h required 1", d); end
      bus_write(AW'(4), 4'hF, 32'h1, lat, acc);
      @(negedge aclk);
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_deassert: got %b required 0", irq); end
      bus_read(AW'(4), d, lat, acc);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h required 0", d); end
   endtask

   task automatic test_counter();
      logic [31:0] lo, hi;
      int lat, w, a1, a2;
      bus_write(AW'(2), 4'hF, 32'h1, lat, w);
      n_tests++;
      if (ctrl_o !== 32'h1) begin n_fail++; $display("FAIL ctrl_o_enable: got %h required 1", ctrl_o); end
      repeat (100) @(negedge aclk);
      bus_read(AW'(6), lo, lat, a1);
      n_tests++;
      if (lo !== 32'(a1 - w - 1)) begin
         n_fail++; $display("FAIL cnt_lo_first: got %0d required %0d", lo, a1 - w - 1);
      end
      repeat (10) @(negedge aclk);
      bus_read(AW'(7), hi, lat, a2);
      n_tests++;
      if (hi !== 32'h0) begin n_fail++; $display("FAIL cnt_hi_snapshot: got %h required 0", hi); end
      bus_read(AW'(6), lo, lat, a2);
      n_tests++;
      if (lo !== 32'(a2 - w - 1)) begin
         n_fail++; $display("FAIL cnt_lo_second: got %0d required %0d", lo, a2 - w - 1);
      end
   endtask

   task automatic test_wrap();
      logic [63:0] base, e;
      logic [31:0] lo, hi, d;
      int lat, r, a, w;
      base = 64'hFFFF_FFFF_FFFF_FFFE;
      @(negedge aclk);
      force dut.cnt_q = base;
      @(negedge aclk);
      release dut.cnt_q;
      r = cyc;
      for (int k = 0; k < 2; k++) begin
         bus_read(AW'(6), lo, lat, a);
         e = base + 64'(a - r - 1);
         n_tests++;
         if (lo !== e[31:0]) begin
            n_fail++; $display("FAIL wrap_lo[%0d]: got %h required %h", k, lo, e[31:0]);
         end
         repeat (2) @(negedge aclk);
         bus_read(AW'(7), hi, lat, a);
         n_tests++;
         if (hi !== e[63:32]) begin
            n_fail++; $display("FAIL wrap_hi[%0d]: got %h required %h", k, hi, e[63:32]);
         end
      end
      bus_write(AW'(2), 4'hF, 32'h3, lat, w);
      n_tests++;
      if (ctrl_o !== 32'h1) begin n_fail++; $display("FAIL ctrl_clr_bit: got %h required 1", ctrl_o); end
      bus_read(AW'(6), lo, lat, a);
      n_tests++;
      if (lo !== 32'(a - w - 1)) begin
         n_fail++; $display("FAIL cnt_after_clear: got %0d required %0d", lo, a - w - 1);
      end
      bus_read(AW'(2), d, lat, a);
      n_tests++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL ctrl_read: got %h required 1", d); end
      bus_write(AW'(2), 4'hF, 32'h0, lat, w);
   endtask

   task automatic test_unmapped();
      logic [31:0] d;
      int lat, acc;
      bus_write(AW'(40), 4'hF, 32'hDEAD_BEEF, lat, acc);
      n_tests++;
      if (lat !== 1) begin n_fail++; $display("FAIL unmapped_wr_ack: got %0d required 1", lat); end
      bus_read(AW'(40), d, lat, acc);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h required 0", d); end
      bus_read(AW'(1), d, lat, acc);
      n_tests++;
      if (d !== exp_scratch) begin
         n_fail++; $display("FAIL unmapped_scratch: got %h required %h", d, exp_scratch);
      end
      bus_read(AW'(5), d, lat, acc);
      n_tests++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL unmapped_int_en: got %h required 1", d); end
      n_tests++;
      if (ctrl_o !== 32'h0) begin n_fail++; $display("FAIL unmapped_ctrl: got %h required 0", ctrl_o); end
   endtask

   task automatic test_random();
      logic [31:0] m_scratch, m_ctrl, m_tmp, d, dat, e;
      logic [7:0]  m_stat, m_en, m_src, nsrc;
      logic [3:0]  be;
      logic [AW-1:0] a;
      int lat, acc, sel;
      bit is_wr;
      m_scratch = $urandom;
      bus_write(AW'(1), 4'hF, m_scratch, lat, acc);
      bus_write(AW'(2), 4'hF, 32'h0, lat, acc);
      bus_write(AW'(5), 4'hF, 32'h0, lat, acc);
      bus_write(AW'(4), 4'hF, 32'hFF, lat, acc);
      m_ctrl = 32'h0; m_en = 8'h0; m_stat = 8'h0; m_src = irq_src_i;
      for (int it = 0; it < 150; it++) begin
         @(negedge aclk);
         n_tests++;
         if (irq !== (|(m_stat & m_en))) begin
            n_fail++; $display("FAIL rand_irq[%0d]: got %b required %b", it, irq, |(m_stat & m_en));
         end
         n_tests++;
         if (ctrl_o !== m_ctrl) begin
            n_fail++; $display("FAIL rand_ctrl_o[%0d]: got %h required %h", it, ctrl_o, m_ctrl);
         end
         nsrc = m_src ^ (8'($urandom) & 8'($urandom));
         irq_src_i = nsrc;
         m_stat = m_stat | (nsrc & ~m_src);
         m_src = nsrc;
         status_i = $urandom;
         is_wr = 1'($urandom);
         sel = $urandom_range(0, 8);
         a = (sel == 8) ? AW'($urandom_range(8, 1023)) : AW'(sel);
         be = 4'($urandom);
         dat = $urandom;
         if (is_wr) begin
            bus_write(a, be, dat, lat, acc);
            case (a)
               AW'(1): m_scratch = merge(m_scratch, dat, be);
               AW'(2): m_ctrl = merge(m_ctrl, dat, be) & ~32'h2;
               AW'(4): m_stat = m_stat & ~(dat[7:0] & {8{be[0]}});
               AW'(5): begin m_tmp = merge({24'h0, m_en}, dat, be); m_en = m_tmp[7:0]; end
               default: ;
            endcase
            n_tests++;
            if (lat !== 1) begin n_fail++; $display("FAIL rand_wr_lat[%0d]: got %0d required 1", it, lat); end
         end else begin
            if (a == AW'(6) || a == AW'(7)) a = AW'(3);
            bus_read(a, d, lat, acc);
            case (a)
               AW'(0): e = ID_VAL;
               AW'(1): e = m_scratch;
               AW'(2): e = m_ctrl;
               AW'(3): e = status_i;
               AW'(4): e = {24'h0, m_stat};
               AW'(5): e = {24'h0, m_en};
               default: e = 32'h0;
            endcase
            n_tests++;
            if (d !== e || lat !== 1) begin
               n_fail++;
               $display("FAIL rand_rd[%0d] idx %0d: got %h lat %0d required %h lat 1", it, a, d, lat, e);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] idx [7];
      logic [31:0]   exp [7];
      logic [31:0]   d;
      int lat, acc;
      idx = '{AW'(0), AW'(1), AW'(2), AW'(4), AW'(5), AW'(6), AW'(7)};
      exp = '{ID_VAL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      bus_write(AW'(1), 4'hF, 32'h1357_9BDF, lat, acc);
      @(negedge aclk);
      wr_addr = AW'(1); wr_be = 4'hF; wr_data = 32'hCAFE_F00D; wr_req = 1'b1;
      areset = 1'b1; irq_src_i = 8'h00;
      for (int k = 0; k < 2; k++) begin
         @(negedge aclk);
         n_tests++;
         if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_drop_ack[%0d]: got %b required 0", k, wr_ack); end
      end
      wr_req = 1'b0;
      areset = 1'b0;
      n_tests++;
      if ({irq, ctrl_o, rd_data} !== 65'h0) begin
         n_fail++; $display("FAIL reset_mid_outputs: got %h required 0", {irq, ctrl_o, rd_data});
      end
      for (int i = 0; i < 7; i++) begin
         bus_read(idx[i], d, lat, acc);
         n_tests++;
         if (d !== exp[i]) begin
            n_fail++; $display("FAIL reset_mid_read[%0d]: got %h required %h", idx[i], d, exp[i]);
         end
      end
   endtask

   initial begin
      areset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_be = 4'h0; wr_data = 32'h0;
      status_i = 32'h0; irq_src_i = 8'h00; exp_scratch = 32'h0;
      test_reset();
      test_scratch();
      test_irq();
      test_counter();
      test_wrap();
      test_unmapped();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_tests);
      $fatal(1);
   end

endmodule
